ycbcr_skin_bin: RTL

Skin-colour segmentation stage placed directly downstream of rgb2ycbcr. It consumes the Y/Cb/Cr stream and its de/hsync/vsync, and emits a binary mask (0x00/0xFF) with delay-matched sync signals. The mask can be fed straight into hdmi_out as {8'b0, bin, bin, bin}. Per frame it also accumulates the skin-pixel count and the bounding box, and publishes both at the frame boundary.

---
 rtl/skin_pkg.sv | 16 +
 rtl/pix_coord.sv | 52 +++++
 rtl/ycbcr_skin_bin.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/skin_pkg.sv
// rtl/skin_pkg.sv - shared defaults for the YCbCr skin segmentation stage
package skin_pkg;

  localparam int SKIN_CB_MIN = 77;
  localparam int SKIN_CB_MAX = 127;
  localparam int SKIN_CR_MIN = 133;
  localparam int SKIN_CR_MAX = 173;

  localparam int SKIN_XW = 11;
  localparam int SKIN_YW = 11;
  localparam int SKIN_CW = 21;

  localparam logic [7:0] BIN_ON  = 8'hFF;
  localparam logic [7:0] BIN_OFF = 8'h00;

endpackage

// File: rtl/pix_coord.sv
// rtl/pix_coord.sv - de/vsync edge detection and saturating pixel column/line counters
module pix_coord
  import skin_pkg::*;
#(
  parameter int XW = SKIN_XW,
  parameter int YW = SKIN_YW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          de,
  input  logic          vsync,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          line_end,
  output logic          frame_start
);

  logic          de_q;
  logic          vs_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;

  assign line_end    = ce & de_q & ~de;
  assign frame_start = ce & ~vs_q & vsync;
  assign x           = x_q;
  // A pixel coinciding with the frame edge already belongs to line 0 of the new frame.
  assign y           = frame_start ? '0 : y_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_q <= 1'b0;
      vs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else if (ce) begin
      de_q <= de;
      vs_q <= vsync;
      if (de) begin
        if (x_q != '1) x_q <= x_q + 1'b1;
      end else if (line_end) begin
        x_q <= '0;
      end
      if (frame_start) begin
        y_q <= '0;
      end else if (line_end && (y_q != '1)) begin
        y_q <= y_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ycbcr_skin_bin.sv
// rtl/ycbcr_skin_bin.sv - Cb/Cr skin threshold to binary mask with per-frame count and bounding box
module ycbcr_skin_bin
  import skin_pkg::*;
#(
  parameter int CB_MIN = SKIN_CB_MIN,
  parameter int CB_MAX = SKIN_CB_MAX,
  parameter int CR_MIN = SKIN_CR_MIN,
  parameter int CR_MAX = SKIN_CR_MAX,
  parameter int XW     = SKIN_XW,
  parameter int YW     = SKIN_YW,
  parameter int CW     = SKIN_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          de_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic [7:0]    y_in,
  input  logic [7:0]    cb_in,
  input  logic [7:0]    cr_in,
  output logic          de_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic [7:0]    bin_out,
  output logic [CW-1:0] skin_count,
  output logic [XW-1:0] x_min,
  output logic [XW-1:0] x_max,
  output logic [YW-1:0] y_min,
  output logic [YW-1:0] y_max,
  output logic          bbox_valid,
  output logic          frame_done
);

  localparam logic [7:0] CB_LO = 8'(CB_MIN);
  localparam logic [7:0] CB_HI = 8'(CB_MAX);
  localparam logic [7:0] CR_LO = 8'(CR_MIN);
  localparam logic [7:0] CR_HI = 8'(CR_MAX);

  logic          cb_ok_s1, cr_ok_s1, de_s1, hs_s1, vs_s1;
  logic          skin_s2, de_s2, hs_s2, vs_s2;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic          frame_start, unused_line_end, unused_y;

  logic [CW-1:0] cnt, cnt_base;
  logic [XW-1:0] xmin, xmax, xmin_base, xmax_base;
  logic [YW-1:0] ymin, ymax, ymin_base, ymax_base;
  logic          found, found_base;

  assign unused_y  = ^y_in;
  assign de_out    = de_s2;
  assign hsync_out = hs_s2;
  assign vsync_out = vs_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {cb_ok_s1, cr_ok_s1, de_s1, hs_s1, vs_s1} <= '0;
      {skin_s2, de_s2, hs_s2, vs_s2}            <= '0;
      bin_out                                   <= BIN_OFF;
    end else if (ce) begin
      cb_ok_s1 <= (cb_in >= CB_LO) && (cb_in <= CB_HI);
      cr_ok_s1 <= (cr_in >= CR_LO) && (cr_in <= CR_HI);
      de_s1    <= de_in;
      hs_s1    <= hsync_in;
      vs_s1    <= vsync_in;
      skin_s2  <= cb_ok_s1 & cr_ok_s1 & de_s1;
      bin_out  <= (cb_ok_s1 & cr_ok_s1 & de_s1) ? BIN_ON : BIN_OFF;
      de_s2    <= de_s1;
      hs_s2    <= hs_s1;
      vs_s2    <= vs_s1;
    end
  end

  pix_coord #(.XW(XW), .YW(YW)) u_coord (
    .clk         (clk),
    .rst_n       (rst_n),
    .ce          (ce),
    .de          (de_s2),
    .vsync       (vs_s2),
    .x           (px),
    .y           (py),
    .line_end    (unused_line_end),
    .frame_start (frame_start)
  );

  // The frame-edge clear is applied first so a coincident skin pixel seeds the new frame.
  always_comb begin
    cnt_base   = frame_start ? '0   : cnt;
    xmin_base  = frame_start ? '1   : xmin;
    xmax_base  = frame_start ? '0   : xmax;
    ymin_base  = frame_start ? '1   : ymin;
    ymax_base  = frame_start ? '0   : ymax;
    found_base = frame_start ? 1'b0 : found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      xmin       <= '0;
      xmax       <= '0;
      ymin       <= '0;
      ymax       <= '0;
      found      <= 1'b0;
      skin_count <= '0;
      x_min      <= '0;
      x_max      <= '0;
      y_min      <= '0;
      y_max      <= '0;
      bbox_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_start;
      if (ce) begin
        if (frame_start) begin
          skin_count <= cnt;
          bbox_valid <= found;
          x_min      <= found ? xmin : '0;
          x_max      <= found ? xmax : '0;
          y_min      <= found ? ymin : '0;
          y_max      <= found ? ymax : '0;
        end
        if (skin_s2) begin
          cnt   <= (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
          xmin  <= (px < xmin_base) ? px : xmin_base;
          xmax  <= (px > xmax_base) ? px : xmax_base;
          ymin  <= (py < ymin_base) ? py : ymin_base;
          ymax  <= (py > ymax_base) ? py : ymax_base;
          found <= 1'b1;
        end else begin
          cnt   <= cnt_base;
          xmin  <= xmin_base;
          xmax  <= xmax_base;
          ymin  <= ymin_base;
          ymax  <= ymax_base;
          found <= found_base;
        end
      end
    end
  end

endmodule
